bf_iteration_controller: RTL
============================

# bf_iteration_controller

Sequencer for one Bellman-Ford relaxation engine. It owns the phase counter and the iteration FSM that drive the AGU's enables and rollover strobes. It runs relaxation passes over all DRAM columns until no distance changes or until the maximum pass count is reached, then runs one extra detection pass for negative cycles. It sits between the top-level start/abort control and the AGU/relaxation datapath.

## Interface
- NUM_COLUMNS, 768: columns per pass; must match the AGU.
- PHASE_COUNT, 4: clock cycles per column; must be at least 2.
- MAX_ITERATIONS, 31: number of relaxation passes (vertices − 1).
- CNT_W, 6: pass counter width, at least clog2(MAX_ITERATIONS+2).
- clk in 1: the single clock.
- rst_global in 1: asynchronous, active-high reset.
- start in 1: one-cycle request to begin a run; ignored unless the state is IDLE or DONE.
- abort in 1: one-cycle request; returns the block to IDLE.
- iteration_done in 1: AGU level, high while the write address is the last column.
- relax_changed in 1: datapath; high in any cycle a distance was updated.
- read_enable_cu out 1: AGU extra read advance; held 0 by this block (reserved).
- write_enable_cu out 1: AGU extra write advance; held 0 (reserved).
- pre_rollover_phase_counter out 1: AGU read advance strobe.
- rollover_phase_counter out 1: AGU write advance strobe.
- agu_clear out 1: one-cycle pulse, ORed into the AGU reset.
- phase out clog2(PHASE_COUNT): current phase, used by the datapath.
- pass_count out CNT_W: number of completed passes.
- busy out 1: high in every state except IDLE and DONE.
- done out 1: high in DONE.
- converged out 1: result flag, valid while done is high.
- negative_cycle out 1: result flag, valid while done is high.

## Operation
- States: IDLE, CLEAR, RUN, EVAL, DONE.
- IDLE or DONE, on start: go to CLEAR. Clear pass_count, converged, negative_cycle and the sticky flag.
- CLEAR: agu_clear=1 for exactly this one cycle, then go to RUN with phase=0.
- RUN, phase counter:
  - phase increments each cycle and wraps from PHASE_COUNT−1 to 0.
  - pre_rollover_phase_counter = (phase == PHASE_COUNT−2).
  - rollover_phase_counter = (phase == PHASE_COUNT−1).
  - Both strobes are 0 outside RUN.
- Sticky flag `changed`: set by relax_changed in RUN or EVAL. Cleared on entry to RUN from CLEAR or EVAL.
- Pass end: in RUN, when rollover_phase_counter and iteration_done are both high, go to EVAL. pass_count increments in the same edge.
- EVAL (one cycle): phase is held at 0 and no strobes are issued. Decision, in priority order:
  - pass_count == MAX_ITERATIONS+1 (the detection pass): set negative_cycle = changed, converged = ~changed, go to DONE.
  - ~changed: set converged=1, go to DONE.
  - otherwise: go to RUN. This includes pass_count == MAX_ITERATIONS, which starts the detection pass.
- DONE: hold the flags and pass_count until the next start or abort.
- abort in any state: next state is IDLE and phase=0. agu_clear=1 for that one cycle, unless the block was already in IDLE. Flags are cleared. abort has priority over start.
- relax_changed in IDLE, CLEAR or DONE is ignored.

## Timing
- Reset values: state IDLE, and every output 0 (phase=0, pass_count=0, all strobes and flags 0).
- Outputs are registered or decoded from registers only; there is no combinational input-to-output path.
- start at edge t: CLEAR during cycle t+1; RUN with phase=0 from cycle t+2.
- One pass is NUM_COLUMNS×PHASE_COUNT RUN cycles plus 1 EVAL cycle.
- The first rollover of a pass occurs in its PHASE_COUNT-th RUN cycle.
- relax_changed asserted in the last RUN cycle of a pass counts for that pass.
- Abort or reset in mid-pass leaves no residual state. The next start behaves exactly as from reset.

## Structure
- Package bf_ctrl_pkg holds the state enum (IDLE=0, CLEAR=1, RUN=2, EVAL=3, DONE=4) and the default parameter constants. The AGU shares NUM_COLUMNS.
- Sub-module bf_phase_counter covers the phase register and both rollover decodes. Its ports are clk, rst_global, clear, enable, phase, pre_rollover and rollover.
- The FSM, pass counter and result flags live in the top.

## Test plan
Run all scenarios with a behavioural AGU model, NUM_COLUMNS=4, PHASE_COUNT=4, MAX_ITERATIONS=3.
- Reset, then start with relax_changed always 0:
  - one pass of 16 RUN cycles, then EVAL;
  - done, converged=1, negative_cycle=0, pass_count=1;
  - done rises 19 cycles after start.
- relax_changed pulses once in each of the first 2 passes: converged=1 after pass 3, pass_count=3.
- relax_changed pulses in every pass: 4 passes (3 plus detection), then negative_cycle=1, converged=0, pass_count=4.
- Strobe checks:
  - pre_rollover high at phase 2, rollover at phase 3, exactly 4 of each per pass;
  - both low in EVAL;
  - agu_clear is exactly one pulse after start.
- abort at the 7th RUN cycle of pass 2: IDLE next cycle, agu_clear pulse, all outputs 0; a following start yields a normal run.
- start during RUN, abort together with start, and asynchronous rst_global mid-EVAL:
  - start during RUN is ignored;
  - abort together with start gives IDLE;
  - rst_global gives all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bf_ctrl_pkg.sv
// Shared definitions for the Bellman-Ford iteration controller: FSM state
// encoding and default sizing constants (NUM_COLUMNS is shared with the AGU).
package bf_ctrl_pkg;

  localparam int DEF_NUM_COLUMNS    = 768;
  localparam int DEF_PHASE_COUNT    = 4;
  localparam int DEF_MAX_ITERATIONS = 31;
  localparam int DEF_CNT_W          = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DONE  = 3'd4
  } bf_state_e;

endpackage

// File: rtl/bf_phase_counter.sv
// Per-column phase counter with the two AGU advance strobes decoded from the
// registered phase; strobes are gated by enable so they are silent outside RUN.
module bf_phase_counter
  import bf_ctrl_pkg::*;
#(
  parameter int PHASE_COUNT = DEF_PHASE_COUNT,
  parameter int PHASE_W     = $clog2(PHASE_COUNT)
) (
  input  logic               clk,
  input  logic               rst_global,
  input  logic               clear,
  input  logic               enable,
  output logic [PHASE_W-1:0] phase,
  output logic               pre_rollover,
  output logic               rollover
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASE_COUNT - 1);
  localparam logic [PHASE_W-1:0] PRE_PHASE  = PHASE_W'(PHASE_COUNT - 2);

  logic [PHASE_W-1:0] r_phase;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst_global) begin
    if (rst_global) begin
      r_phase <= '0;
    end else if (clear) begin
      r_phase <= '0;
    end else if (enable) begin
      r_phase <= (r_phase == LAST_PHASE) ? '0 : r_phase + PHASE_W'(1);
    end
  end

  assign phase        = r_phase;
  assign pre_rollover = enable && (r_phase == PRE_PHASE);
  assign rollover     = enable && (r_phase == LAST_PHASE);

endmodule

// File: rtl/bf_iteration_controller.sv
// Sequencer for one Bellman-Ford relaxation engine: runs relaxation passes until
// distances settle or the pass limit is hit, then one negative-cycle detection pass.
module bf_iteration_controller
  import bf_ctrl_pkg::*;
#(
  parameter int NUM_COLUMNS    = DEF_NUM_COLUMNS,
  parameter int PHASE_COUNT    = DEF_PHASE_COUNT,
  parameter int MAX_ITERATIONS = DEF_MAX_ITERATIONS,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           rst_global,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           iteration_done,
  input  logic                           relax_changed,
  output logic                           read_enable_cu,
  output logic                           write_enable_cu,
  output logic                           pre_rollover_phase_counter,
  output logic                           rollover_phase_counter,
  output logic                           agu_clear,
  output logic [$clog2(PHASE_COUNT)-1:0] phase,
  output logic [CNT_W-1:0]               pass_count,
  output logic                           busy,
  output logic                           done,
  output logic                           converged,
  output logic                           negative_cycle
);

  localparam int                PHASE_W     = $clog2(PHASE_COUNT);
  localparam logic [CNT_W-1:0]  DETECT_PASS = CNT_W'(MAX_ITERATIONS + 1);

  if (PHASE_COUNT < 2) begin : g_bad_phase_count
    $error("bf_iteration_controller: PHASE_COUNT must be at least 2");
  end
  if (NUM_COLUMNS < 1) begin : g_bad_num_columns
    $error("bf_iteration_controller: NUM_COLUMNS must be at least 1");
  end
  if (CNT_W < $clog2(MAX_ITERATIONS + 2)) begin : g_bad_cnt_w
    $error("bf_iteration_controller: CNT_W too narrow for MAX_ITERATIONS+1");
  end

  bf_state_e          r_state;
  bf_state_e          w_next_state;
  logic [CNT_W-1:0]   r_pass_count;
  logic               r_changed;
  logic               r_converged;
  logic               r_negative_cycle;
  logic               r_agu_clear;
  logic               w_run;
  logic               w_phase_clear;
  logic               w_pre_rollover;
  logic               w_rollover;
  logic               w_pass_end;
  logic               w_start_ok;
  logic               w_changed_now;
  logic               w_detect_pass;
  logic [PHASE_W-1:0] w_phase;

  assign w_run         = (r_state == ST_RUN);
  assign w_phase_clear = abort || (r_state == ST_CLEAR);
  assign w_start_ok    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_pass_end    = w_rollover && iteration_done;
  assign w_changed_now = r_changed || relax_changed;
  assign w_detect_pass = (r_pass_count == DETECT_PASS);

  bf_phase_counter #(
    .PHASE_COUNT (PHASE_COUNT),
    .PHASE_W     (PHASE_W)
  ) u_phase_counter (
    .clk          (clk),
    .rst_global   (rst_global),
    .clear        (w_phase_clear),
    .enable       (w_run),
    .phase        (w_phase),
    .pre_rollover (w_pre_rollover),
    .rollover     (w_rollover)
  );

  always_ff @(posedge clk or posedge rst_global) begin
    if (rst_global) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: next_state gets its default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: if (start) w_next_state = ST_CLEAR;
        ST_CLEAR:         w_next_state = ST_RUN;
        ST_RUN:           if (w_pass_end) w_next_state = ST_EVAL;
        ST_EVAL:          w_next_state = (w_detect_pass || !w_changed_now) ? ST_DONE : ST_RUN;
        default:          w_next_state = ST_IDLE;
      endcase
    end
  end

  // Pass counter, sticky change flag and result flags; abort wipes all of them
  // so a later start behaves exactly as after reset.
  always_ff @(posedge clk or posedge rst_global) begin
    if (rst_global) begin
      r_pass_count     <= '0;
      r_changed        <= 1'b0;
      r_converged      <= 1'b0;
      r_negative_cycle <= 1'b0;
      r_agu_clear      <= 1'b0;
    end else begin
      r_agu_clear <= abort ? (r_state != ST_IDLE) : w_start_ok;
      if (abort) begin
        r_pass_count     <= '0;
        r_changed        <= 1'b0;
        r_converged      <= 1'b0;
        r_negative_cycle <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              r_pass_count     <= '0;
              r_changed        <= 1'b0;
              r_converged      <= 1'b0;
              r_negative_cycle <= 1'b0;
            end
          end
          ST_CLEAR: r_changed <= 1'b0;
          ST_RUN: begin
            if (relax_changed) r_changed <= 1'b1;
            if (w_pass_end) r_pass_count <= r_pass_count + CNT_W'(1);
          end
          ST_EVAL: begin
            if (w_detect_pass) begin
              r_negative_cycle <= w_changed_now;
              r_converged      <= !w_changed_now;
            end else if (!w_changed_now) begin
              r_converged <= 1'b1;
            end else begin
              r_changed <= 1'b0;
            end
          end
          default: r_changed <= 1'b0;
        endcase
      end
    end
  end

  assign read_enable_cu             = 1'b0;
  assign write_enable_cu            = 1'b0;
  assign pre_rollover_phase_counter = w_pre_rollover;
  assign rollover_phase_counter     = w_rollover;
  assign agu_clear                  = r_agu_clear;
  assign phase                      = w_phase;
  assign pass_count                 = r_pass_count;
  assign busy                       = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done                       = (r_state == ST_DONE);
  assign converged                  = r_converged;
  assign negative_cycle             = r_negative_cycle;

endmodule
